// File: rtl/divu_iter_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding,
// default width and the ALU opcode that routes to this unit.
package divu_iter_pkg;
   localparam int DIV_WIDTH = 32;
   localparam logic [5:0] DIV_OP = 6'h1b;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;
endpackage

// File: rtl/divu_iter_if.sv
// Request/response bundle between the ALU (master) and the divider (slave).
// signed_op exists only when DIVU_ITER_SIGNED_EN is defined.
interface divu_iter_if #(parameter int WIDTH = 32);
`ifdef DIVU_ITER_SIGNED_EN
   logic             signed_op;
`endif
   logic             start;
   logic             flush;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
`ifdef DIVU_ITER_SIGNED_EN
      output signed_op,
`endif
      output start, flush, a, b,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
`ifdef DIVU_ITER_SIGNED_EN
      input  signed_op,
`endif
      input  start, flush, a, b,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divu_iter_div_step.sv
// One restoring step: shift in the next dividend bit, subtract the divisor
// if it fits. The compare is WIDTH+1 bits so the shifted value never overflows.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, div_i};
      q_o     = ~diff[WIDTH];
      rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/divu_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Define DIVU_ITER_SIGNED_EN to add signed division via signed_op.
module divu_iter
   import divu_iter_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic        clk_i,
   input  logic        rst_i,
   divu_iter_if.slave  dif
);
   div_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, dvd_q, dvs_q, quo_q, rmd_q;
   logic             busy_q, done_q, dbz_q, qneg_q, rneg_q;

   logic             sop, accept, a_neg, b_neg, step_q;
   logic [WIDTH-1:0] a_mag, b_mag, step_rem, quo_d, rmd_d;

`ifdef DIVU_ITER_SIGNED_EN
   assign sop = dif.signed_op;
`else
   assign sop = 1'b0;
`endif

   assign accept = dif.start && !dif.flush;
   assign a_neg  = sop && dif.a[WIDTH-1];
   assign b_neg  = sop && dif.b[WIDTH-1];
   assign a_mag  = a_neg ? -dif.a : dif.a;
   assign b_mag  = b_neg ? -dif.b : dif.b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[WIDTH-1]),
      .div_i (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   // Quotient bits shift into the dividend register as its bits are consumed.
   always_comb begin
      quo_d = {dvd_q[WIDTH-2:0], step_q};
      rmd_d = step_rem;
      if (qneg_q) quo_d = -quo_d;
      if (rneg_q) rmd_d = -rmd_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rmd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         case (state_q)
            DIV_RUN: begin
               if (dif.flush) begin
                  state_q <= DIV_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_q <= step_rem;
                  dvd_q <= {dvd_q[WIDTH-2:0], step_q};
                  if (cnt_q == CNT_W'(WIDTH-1)) begin
                     state_q <= DIV_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     quo_q   <= quo_d;
                     rmd_q   <= rmd_d;
                     dbz_q   <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               done_q <= 1'b0;
               if (accept && dif.b == '0) begin
                  // Zero divisor completes on the accepting edge.
                  state_q <= DIV_DONE;
                  done_q  <= 1'b1;
                  quo_q   <= '1;
                  rmd_q   <= dif.a;
                  dbz_q   <= 1'b1;
               end else if (accept) begin
                  state_q <= DIV_RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  dvd_q   <= a_mag;
                  dvs_q   <= b_mag;
                  qneg_q  <= a_neg ^ b_neg;
                  rneg_q  <= a_neg;
               end else begin
                  state_q <= DIV_IDLE;
               end
            end
         endcase
      end
   end

   assign dif.busy        = busy_q;
   assign dif.done        = done_q;
   assign dif.quotient    = quo_q;
   assign dif.remainder   = rmd_q;
   assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divu_iter.sv
// Scoreboard bench for divu_iter: expectations queued at start, checked on done.
module tb_divu_iter;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   divu_iter_if #(.WIDTH(W)) dif();
   divu_iter #(.WIDTH(W), .CNT_W(6)) dut (.clk_i(clk), .rst_i(rst), .dif(dif));

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } res_t;

   res_t sb[$];
   res_t exp_m;
   int   total = 0;
   int   bad   = 0;
   int   n_done = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop);
      res_t e;
      e.dbz = (b == '0);
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else if (sop && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = 32'h8000_0000;
         e.r = '0;
      end else if (sop) begin
         e.q = $signed(a) / $signed(b);
         e.r = $signed(a) % $signed(b);
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst && dif.done) begin
         n_done++;
         if (sb.size() == 0) chk("spurious_done", dif.done, 1'b0);
         else begin
            exp_m = sb.pop_front();
            chk("quo", dif.quotient, exp_m.q);
            chk("rem", dif.remainder, exp_m.r);
            chk("dbz", dif.div_by_zero, exp_m.dbz);
         end
      end
   end

   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop, input bit push);
      dif.a = a;
      dif.b = b;
`ifdef DIVU_ITER_SIGNED_EN
      dif.signed_op = sop;
`endif
      dif.start = 1'b1;
      if (push) sb.push_back(model(a, b, sop));
      tick();
      dif.start = 1'b0;
   endtask

   // Called in cycle 1 after go; returns in the done cycle.
   task automatic wait_done(input string tag, input int exp_lat);
      int cyc = 1;
      int nb  = 0;
      while (!dif.done && cyc < 300) begin
         if (!dif.busy) nb++;
         tick();
         cyc++;
      end
      chk({tag, "_lat"}, cyc, exp_lat);
      chk({tag, "_busy_gap"}, nb, 0);
      chk({tag, "_busy_at_done"}, dif.busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      logic [W-1:0] ra, rb;
`ifdef DIVU_ITER_SIGNED_EN
      dif.signed_op = 1'b0;
`endif
      dif.start = 1'b0;
      dif.flush = 1'b0;
      dif.a = '0;
      dif.b = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", dif.busy, 1'b0);
      chk("rst_done", dif.done, 1'b0);
      chk("rst_quo", dif.quotient, '0);
      chk("rst_rem", dif.remainder, '0);
      chk("rst_dbz", dif.div_by_zero, 1'b0);

      // 100/7 and result hold
      go(100, 7, 1'b0, 1'b1);
      wait_done("d100_7", 33);
      tick();
      chk("done_pulse", dif.done, 1'b0);
      repeat (3) tick();
      chk("hold_quo", dif.quotient, 14);
      chk("hold_rem", dif.remainder, 2);

      // back-to-back: second start in the first done cycle
      go(32'hFFFF_FFFF, 1, 1'b0, 1'b1);
      wait_done("max_1", 33);
      go(32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b1);
      wait_done("b2b", 33);

      // divide by zero then a normal divide
      tick();
      go(5, 0, 1'b0, 1'b1);
      wait_done("dbz", 1);
      tick();
      go(9, 3, 1'b0, 1'b1);
      wait_done("d9_3", 33);
      tick();

      // flush mid-run, ignored starts during RUN
      d0 = n_done;
      go(1000, 3, 1'b0, 1'b0);
      tick();
      for (int c = 2; c <= 9; c++) begin
         dif.start = 1'b1; dif.a = 1; dif.b = 1;
         tick();
      end
      dif.start = 1'b0;
      dif.flush = 1'b1;
      tick();
      dif.flush = 1'b0;
      chk("flush_busy", dif.busy, 1'b0);
      repeat (40) tick();
      chk("flush_no_done", n_done, d0);
      chk("flush_hold_quo", dif.quotient, 3);
      chk("flush_hold_rem", dif.remainder, 0);

      // flush wins over a simultaneous start in IDLE
      dif.a = 6; dif.b = 0; dif.start = 1'b1; dif.flush = 1'b1;
      tick();
      dif.start = 1'b0; dif.flush = 1'b0;
      chk("flush_start_busy", dif.busy, 1'b0);
      chk("flush_start_done", dif.done, 1'b0);
      tick();

      // reset mid-run
      d0 = n_done;
      go(1000, 3, 1'b0, 1'b0);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_busy", dif.busy, 1'b0);
      chk("mrst_quo", dif.quotient, '0);
      chk("mrst_rem", dif.remainder, '0);
      repeat (40) tick();
      chk("mrst_no_done", n_done, d0);
      go(8, 2, 1'b0, 1'b1);
      wait_done("d8_2", 33);
      tick();

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         go(ra, rb, 1'b0, 1'b1);
         wait_done("rnd", (rb == '0) ? 1 : 33);
         tick();
      end

`ifdef DIVU_ITER_SIGNED_EN
      go(32'hFFFF_FFF9, 2, 1'b1, 1'b1);
      wait_done("s_m7_2", 33);
      tick();
      go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      wait_done("s_ovf", 33);
      tick();
      go(32'hFFFF_FFF9, 0, 1'b1, 1'b1);
      wait_done("s_dbz", 1);
      tick();
      go(100, 32'hFFFF_FFF9, 1'b1, 1'b1);
      wait_done("s_100_m7", 33);
      tick();
`endif

      tick();
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/divu_iter.md
Name: divu_iter

Overview:
- Iterative radix-2 restoring divider.
- Serves the ALU's divide requests over a start/busy/done handshake and returns quotient and remainder for the HI/LO registers (quotient→lo, remainder→hi).
- Replaces the single-cycle combinational divide path so the EX stage can stall on busy instead of closing timing on a 32-bit array divider.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request pulse; accepted only when busy==0.
- flush  input  1  synchronous abort of an in-flight divide (pipeline flush).
- a  input  WIDTH  dividend, sampled on the accepting edge.
- b  input  WIDTH  divisor, sampled on the accepting edge.
- busy  output  1  high while a divide is in progress.
- done  output  1  one-cycle pulse; results valid this cycle and held afterwards.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag for the last completed divide; high when b==0.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, counter=0; busy, done, div_by_zero=0; quotient=0; remainder=0. This applies mid-operation: the in-flight divide is discarded and no done is produced.
- States:
  - IDLE: waiting for a request.
  - RUN: one iteration per cycle.
  - DONE: single cycle, done=1.
- Acceptance:
  - start is accepted when start==1, flush==0 and state is IDLE or DONE.
  - The accepting edge E0 latches a and b.
  - A start seen in RUN is ignored; there is no queueing.
- Normal path (b!=0), with start in cycle 0:
  - E0 moves to RUN, clears the partial remainder, loads the dividend shift register and sets counter=0.
  - Each RUN edge shifts the partial remainder left by one and brings in the next dividend MSB.
  - If the shifted partial remainder is >= b, the subtraction is kept and the quotient bit is 1; otherwise the quotient bit is 0.
  - Comparison is unsigned and WIDTH+1 bits wide, so there is no overflow.
  - The edge finishing iteration WIDTH-1 moves to DONE and writes quotient and remainder.
  - Timing: busy=1 in cycles 1..WIDTH; done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32); busy=0 in the done cycle.
- Divide by zero (b==0 at E0):
  - RUN is bypassed; E0 goes directly to DONE.
  - done=1 in cycle 1; quotient = all ones; remainder = a; div_by_zero=1.
- DONE always leaves after one cycle:
  - to RUN if a start is accepted in that cycle (back-to-back allowed);
  - otherwise to IDLE.
- Result hold: quotient, remainder and div_by_zero keep their values until the next completion or reset. A start alone does not clear them.
- Flush:
  - flush=1 in RUN: the next edge goes to IDLE, busy=0, and no done is produced. Outputs keep the previous completed results.
  - flush=1 in IDLE or DONE: go to IDLE; a simultaneous start is dropped (flush wins).
- rst has priority over flush and start.
- Counter stops at WIDTH-1; no wrap-around is possible.

Optional Feature:
- Macro: DIVU_ITER_SIGNED_EN.
- When defined:
  - Adds input port signed_op (1 bit), sampled at E0.
  - With signed_op=1, operands are converted to magnitudes before iterating.
  - On completion, the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, same latency.
  - Signed divide by zero: quotient = all ones, remainder = a.
  - Latency is unchanged; sign correction happens on the DONE-writing edge.
- When undefined: no signed_op port; unsigned only; logic is identical to signed_op=0.

Decomposition:
- Shared macro include: state encodings DIV_IDLE, DIV_RUN, DIV_DONE; the div_op ALU opcode; DIV_WIDTH=32.
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once, its result registered each RUN cycle.

Test Plan:
- 100/7, start cycle 0 → busy cycles 1..32; done only in cycle 33 with quotient=14, remainder=2, div_by_zero=0; outputs held afterwards.
- 0xFFFFFFFF/1 then 0x12345678/0xFFFFFFFF, second start issued in the first done cycle → results 0xFFFFFFFF,0 then 0,0x12345678; second done exactly 33 cycles after the first.
- 5/0 → done in cycle 1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; next 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Start 1000/3, flush in cycle 10 → busy=0 from cycle 11, no done, outputs still hold the prior result; start pulses during cycles 2..9 ignored.
- Start 1000/3, rst in cycle 20 → all outputs 0 next cycle, no done; fresh 8/2 → quotient=4, remainder=0.
- With DIVU_ITER_SIGNED_EN, signed_op=1:
  - 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
